// File: rtl/serial_cmd_rx.sv
// serial_cmd_rx: 3-wire serial command port (SCLK/SEN/SDI, SDO readback) to a
// parallel register-write bus. Serial pins are asynchronous and synchronized
// here; decisions are taken on registered edge pulses of the synchronized lines.
// Build option: define SERIAL_READBACK_EN to enable read frames (READ state,
// sdo/sdo_oe/rd_addr). Without it, read frames are silently dropped.
//
// state | meaning
// IDLE  | waiting for a falling edge on synchronized sen
// SHIFT | frame open, shifting header/data bits in on sclk rises
// READ  | read header accepted, shifting rd_data out on sclk falls
module serial_cmd_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        sen,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic [6:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [6:0]  serial_addr,
  output logic [31:0] serial_data,
  output logic        serial_strobe,
  output logic [5:0]  frame_err
);

`ifdef SERIAL_READBACK_EN
  localparam bit RdbkEn = 1'b1;
`else
  localparam bit RdbkEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    READ  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sen_sync_q, sdi_sync_q;
  logic sclk_dly_q, sen_dly_q, sdi_dly_q;
  logic sclk_rise_q, sclk_fall_q, sen_rise_q, sen_fall_q;
  logic sclk_s, sen_s, sdi_s;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] sr_q, sr_d;
  logic        rw_q, rw_d;
  logic [5:0]  err_q, err_d;
  logic        err_inc;
  logic        strobe_q, strobe_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [6:0]  rd_addr_q, rd_addr_d;
  logic [31:0] out_sr_q, out_sr_d;
  logic        sdo_q, sdo_d;
  logic [1:0]  ld_q, ld_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sen_s  = sen_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

  // Synchronizers and registered edge pulses. Everything resets to 0 so that
  // sen held low across reset never looks like a fresh falling edge; sdi is
  // delayed one more flop so it lines up with the registered sclk pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync_q <= '0;
      sen_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sclk_dly_q  <= 1'b0;
      sen_dly_q   <= 1'b0;
      sdi_dly_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      sen_rise_q  <= 1'b0;
      sen_fall_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sen_sync_q  <= {sen_sync_q[SYNC_STAGES-2:0], sen};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      sclk_dly_q  <= sclk_s;
      sen_dly_q   <= sen_s;
      sdi_dly_q   <= sdi_s;
      sclk_rise_q <= sclk_s & ~sclk_dly_q;
      sclk_fall_q <= ~sclk_s & sclk_dly_q;
      sen_rise_q  <= sen_s & ~sen_dly_q;
      sen_fall_q  <= ~sen_s & sen_dly_q;
    end
  end

  // Next-state, frame shifting, frame evaluation and readback shifting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    rw_d      = rw_q;
    err_inc   = 1'b0;
    strobe_d  = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_addr_d = rd_addr_q;
    out_sr_d  = out_sr_q;
    sdo_d     = sdo_q;
    ld_d      = {ld_q[0], 1'b0};

    case (state_q)
      IDLE: begin
        if (sen_fall_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
          rw_d    = 1'b0;
        end
      end
      SHIFT: begin
        // sen rising beats a coincident sclk edge: that bit is not counted
        if (sen_rise_q) begin
          state_d = IDLE;
          if (cnt_q != 6'd0) begin
            if (!rw_q) begin
              if (cnt_q == 6'd40) begin
                strobe_d = 1'b1;
                addr_d   = sr_q[38:32];
                data_d   = sr_q[31:0];
              end else begin
                err_inc = 1'b1;
              end
            end else if (RdbkEn) begin
              // only a read header cut short can end here with readback on
              err_inc = 1'b1;
            end
          end
        end else if (sclk_rise_q) begin
          sr_d  = {sr_q[38:0], sdi_dly_q};
          cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
          if (cnt_q == 6'd0) begin
            rw_d = sdi_dly_q;
          end
          if (RdbkEn && rw_q && cnt_q == 6'd7) begin
            state_d   = READ;
            rd_addr_d = {sr_q[5:0], sdi_dly_q};
            ld_d[0]   = 1'b1;
          end
        end
      end
      READ: begin
        if (sen_rise_q) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
        end else begin
          if (sclk_fall_q) begin
            sdo_d    = out_sr_q[31];
            out_sr_d = {out_sr_q[30:0], 1'b0};
          end
          // readback mux has had two cycles to settle on rd_addr
          if (ld_q[1]) begin
            out_sr_d = rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (err_inc && err_q != 6'd63) begin
      err_d = err_q + 6'd1;
    end
  end

  // Frame state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      rw_q      <= 1'b0;
      err_q     <= '0;
      strobe_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_addr_q <= '0;
      out_sr_q  <= '0;
      sdo_q     <= 1'b0;
      ld_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      rw_q      <= rw_d;
      err_q     <= err_d;
      strobe_q  <= strobe_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_addr_q <= rd_addr_d;
      out_sr_q  <= out_sr_d;
      sdo_q     <= sdo_d;
      ld_q      <= ld_d;
    end
  end

  assign sdo           = sdo_q;
  assign sdo_oe        = RdbkEn && (state_q == READ);
  assign rd_addr       = rd_addr_q;
  assign serial_addr   = addr_q;
  assign serial_data   = data_q;
  assign serial_strobe = strobe_q;
  assign frame_err     = err_q;

endmodule

// File: doc/serial_cmd_rx.md
# serial_cmd_rx

Front-end serial command port that converts the host's 3-wire serial bus (SCLK/SEN/SDI, plus SDO for readback) into the parallel `serial_addr` / `serial_data` / `serial_strobe` register-write bus. That bus drives the FPGA register consumers, including the GPIO output-enable registers. All serial pins are asynchronous to `clock` and are synchronized internally. The block also serves register readback frames and counts malformed frames.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `sclk`, `sen` and `sdi`; legal range 2..3.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sclk`  in  1  serial clock, asynchronous; its frequency must not exceed `clock`/8.
- `sen`  in  1  serial enable, asynchronous, active-low; low marks a frame.
- `sdi`  in  1  serial data in, MSB first, sampled on `sclk` rising edges.
- `sdo`  out  1  readback data, updated on `sclk` falling edges.
- `sdo_oe`  out  1  output enable for the `sdo` pad.
- `rd_addr`  out  7  readback register address.
- `rd_data`  in  32  readback register value, from the readback mux.
- `serial_addr`  out  7  register address of the last accepted write.
- `serial_data`  out  32  register data of the last accepted write.
- `serial_strobe`  out  1  one-cycle pulse for each accepted write.
- `frame_err`  out  6  count of rejected frames; saturates at 63.

## Operation
- Frame layout, MSB first:
  - bit 0 is R/W (0 = write, 1 = read);
  - bits 1..7 are the address, MSB first;
  - bits 8..39 are the data, MSB first.
- Synchronization and edge detection:
  - `sclk`, `sen` and `sdi` each pass through `SYNC_STAGES` flops.
  - One further register per line provides edge detection.
  - All decisions use the synchronized signals only.
- States:
  - IDLE: entered on reset. Synchronized `sen` falling takes the block to SHIFT and clears the bit counter (6-bit) and the 40-bit shift register.
  - SHIFT: each synchronized `sclk` rise shifts `sdi` into the shift register and increments the counter; the counter saturates at 63. When the counter reaches 8 with R/W = 1, the block goes to READ.
  - READ: `rd_addr` is set to the header address. `rd_data` is captured into a 32-bit output shift register exactly 2 cycles later. On each synchronized `sclk` fall, `sdo` is set to the next bit, MSB first; after bit 0 has been shifted out, `sdo` is 0.
  - On synchronized `sen` rising in any non-IDLE state, the frame is evaluated (rules below) and the block returns to IDLE.
- Frame evaluation:
  - Write frame with count == 40: the block captures `serial_addr` and `serial_data` from the shift register and asserts `serial_strobe` for exactly 1 cycle.
  - Write frame with count of 1..39 or ≥41: no strobe; `frame_err` is incremented.
  - Count == 0 (an SEN glitch): ignored, with no error.
  - Read frame with count ≥ 8: valid, and never strobes.
- `serial_addr` and `serial_data` hold their last accepted values indefinitely.
- `sdo_oe` is 1 only in READ.
- `sen` low while in reset: ignored. After `reset` deasserts, a new frame starts only on a fresh `sen` falling edge.
- Reset in mid-frame:
  - the frame is discarded;
  - no strobe is issued;
  - `frame_err` is cleared.

## Timing
- Reset values:
  - `serial_addr` = 0, `serial_data` = 0, `serial_strobe` = 0;
  - `sdo` = 0, `sdo_oe` = 0;
  - `rd_addr` = 0, `frame_err` = 0.
- Latency from a pin edge to its detection is `SYNC_STAGES`+1 cycles.
- `serial_strobe` is asserted `SYNC_STAGES`+2 cycles after `sen` rises at the pin.
- `serial_addr` and `serial_data` change in the same cycle that `serial_strobe` rises.
- Latency from the pin falling edge of `sclk` to a change on `sdo` is `SYNC_STAGES`+2 cycles.
- `rd_data` must be stable from `rd_addr` update + 2 cycles.
- If synchronized `sen` rises in the same cycle as an `sclk` edge, `sen` wins: the bit is not counted.
- Back-to-back frames require `sen` high for ≥ 2 `clock` cycles after synchronization.

## Configuration
- Macro `SERIAL_READBACK_EN`.
- Defined: READ state, `sdo` and `sdo_oe` behave as specified above.
- Undefined:
  - READ is never entered;
  - `sdo`, `sdo_oe` and `rd_addr` are held at 0;
  - `rd_data` is ignored;
  - read frames of any length produce no strobe and no `frame_err` increment.

## Test plan
- Write frame R/W=0, addr 0x21, data 0xFFFF_00A5 (40 bits) → exactly one `serial_strobe`; `serial_addr` = 0x21, `serial_data` = 0xFFFF00A5, strobe at `sen` rise + 4 cycles (`SYNC_STAGES`=2).
- 39-bit write frame, then 41-bit write frame → no strobe; `frame_err` = 2; `serial_addr` and `serial_data` hold their previous values.
- Read frame for addr 0x05 with `rd_data` = 0x8000_0001 → `rd_addr` = 0x05; `sdo` shows 1, thirty 0s, then 1 on the 32 `sclk` falls; `sdo_oe` is high only during READ.
- `reset` asserted after 20 bits of a write frame, then deasserted with `sen` still low, then `sen` raised → no strobe; `frame_err` = 0; the next full frame is accepted normally.
- 70 consecutive 39-bit frames → `frame_err` saturates at 63.
- With `SERIAL_READBACK_EN` undefined: 40-bit read frame → `sdo_oe` stays 0, no strobe, `frame_err` unchanged.
